// File: rtl/mcu_arb_pkg.sv
// Shared types for the MCU data-memory arbiter: requester IDs and the request beat.
package mcu_arb_pkg;

    localparam int NUM_REQ    = 2;
    // Widest request address the beat struct carries.
    localparam int ARB_ADDR_W = 32;

    typedef enum logic {
        REQ_LSU = 1'b0,
        REQ_AUX = 1'b1
    } req_id_t;

    typedef struct packed {
        logic                  write;
        logic                  lock;
        logic [ARB_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            wstrb;
    } arb_req_t;

endpackage

// File: rtl/mcu_arb_id_fifo.sv
// In-order FIFO of requester IDs for reads awaiting a memory response.
// Latency: head visible the cycle after push; pop is consumed at the clock edge.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module mcu_arb_id_fifo
    import mcu_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  req_id_t                push_id,
    input  logic                   pop,
    output req_id_t                head_id,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

    req_id_t       slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head_id = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/mcu_dmem_arbiter.sv
// Round-robin arbiter with AMO lock between LSU and aux master onto one memory port.
// Latency: grant and response routing are combinational; snoop/error flags one cycle later.
// Backpressure: reads stall at MAX_OUTSTANDING; the non-owner stalls while a lock is held.
module mcu_dmem_arbiter
    import mcu_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = ARB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req_valid,
    output logic              r0_req_ready,
    input  logic              r0_req_write,
    input  logic              r0_req_lock,
    input  logic [ADDR_W-1:0] r0_req_addr,
    input  logic [31:0]       r0_req_wdata,
    input  logic [3:0]        r0_req_wstrb,
    output logic              r0_resp_valid,
    output logic [31:0]       r0_resp_rdata,
    input  logic              r1_req_valid,
    output logic              r1_req_ready,
    input  logic              r1_req_write,
    input  logic              r1_req_lock,
    input  logic [ADDR_W-1:0] r1_req_addr,
    input  logic [31:0]       r1_req_wdata,
    input  logic [3:0]        r1_req_wstrb,
    output logic              r1_resp_valid,
    output logic [31:0]       r1_resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_rdata,
    output logic              snoop_wr_valid,
    output logic [ADDR_W-1:0] snoop_wr_addr,
    output logic              err_stray_resp
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    arb_req_t           req [NUM_REQ];
    arb_req_t           win_req;
    logic [NUM_REQ-1:0] elig;
    req_id_t            last_grant;
    req_id_t            lock_owner;
    req_id_t            win_id;
    req_id_t            head_id;
    logic               lock_active;
    logic               win_vld;
    logic               accept;
    logic               rd_room;
    logic               resp_pop;
    logic [CW-1:0]      fifo_count;
    logic               fifo_empty;
    logic               fifo_full;

    always_comb begin
        req[0]                   = '0;
        req[0].write             = r0_req_write;
        req[0].lock              = r0_req_lock;
        req[0].addr[ADDR_W-1:0]  = r0_req_addr;
        req[0].wdata             = r0_req_wdata;
        req[0].wstrb             = r0_req_wstrb;
        req[1]                   = '0;
        req[1].write             = r1_req_write;
        req[1].lock              = r1_req_lock;
        req[1].addr[ADDR_W-1:0]  = r1_req_addr;
        req[1].wdata             = r1_req_wdata;
        req[1].wstrb             = r1_req_wstrb;
    end

    // Read gating uses the registered count, so a same-cycle pop never makes room.
    assign rd_room = (fifo_count < MAX_CNT);
    assign elig[0] = r0_req_valid && (r0_req_write || rd_room) &&
                     (!lock_active || lock_owner == REQ_LSU);
    assign elig[1] = r1_req_valid && (r1_req_write || rd_room) &&
                     (!lock_active || lock_owner == REQ_AUX);

    always_comb begin
        win_id = REQ_LSU;
        if (elig[1] && (!elig[0] || last_grant == REQ_LSU)) win_id = REQ_AUX;
    end

    assign win_vld = |elig;

    always_comb begin
        win_req = '0;
        if (win_vld) win_req = (win_id == REQ_AUX) ? req[1] : req[0];
    end

    assign mem_req_valid = win_vld;
    assign mem_req_write = win_req.write;
    assign mem_req_addr  = win_req.addr[ADDR_W-1:0];
    assign mem_req_wdata = win_req.wdata;
    assign mem_req_wstrb = win_req.wstrb;

    assign accept       = win_vld && mem_req_ready;
    assign r0_req_ready = accept && (win_id == REQ_LSU);
    assign r1_req_ready = accept && (win_id == REQ_AUX);

    mcu_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (accept && !win_req.write),
        .push_id (win_id),
        .pop     (mem_resp_valid),
        .head_id (head_id),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign resp_pop      = mem_resp_valid && !fifo_empty;
    assign r0_resp_valid = resp_pop && (head_id == REQ_LSU);
    assign r1_resp_valid = resp_pop && (head_id == REQ_AUX);
    assign r0_resp_rdata = r0_resp_valid ? mem_resp_rdata : '0;
    assign r1_resp_rdata = r1_resp_valid ? mem_resp_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant     <= REQ_AUX;
            lock_active    <= 1'b0;
            lock_owner     <= REQ_LSU;
            snoop_wr_valid <= 1'b0;
            snoop_wr_addr  <= '0;
            err_stray_resp <= 1'b0;
        end else begin
            snoop_wr_valid <= accept && (win_id == REQ_AUX) && win_req.write;
            if (accept) begin
                last_grant <= win_id;
                if (win_req.lock) begin
                    lock_active <= 1'b1;
                    lock_owner  <= win_id;
                end else if (win_id == lock_owner) begin
                    lock_active <= 1'b0;
                end
                if (win_id == REQ_AUX && win_req.write)
                    snoop_wr_addr <= {win_req.addr[ADDR_W-1:2], 2'b00};
            end
            if (mem_resp_valid && fifo_empty) err_stray_resp <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (fifo_full == (fifo_count == MAX_CNT));
    end

endmodule
